// File: rtl/text_buffer_scheduler_if.sv
// Write-port bus of the display character buffer: two requester channels,
// the clear control, and the buffer write port driven by the scheduler.
interface text_buffer_scheduler_if #(
  parameter int AW = 9,
  parameter int DW = 32
);
  logic          i_vblank;
  logic          i_cpu_req;
  logic [AW-1:0] i_cpu_addr;
  logic [DW-1:0] i_cpu_data;
  logic          o_cpu_gnt;
  logic          i_kbd_req;
  logic [AW-1:0] i_kbd_addr;
  logic [DW-1:0] i_kbd_data;
  logic          o_kbd_gnt;
  logic          i_clear;
  logic          o_clear_busy;
  logic          o_we;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_range_err;

  modport master (
    output i_vblank, i_cpu_req, i_cpu_addr, i_cpu_data,
    output i_kbd_req, i_kbd_addr, i_kbd_data, i_clear,
    input  o_cpu_gnt, o_kbd_gnt, o_clear_busy,
    input  o_we, o_waddr, o_wdata, o_range_err
  );

  modport slave (
    input  i_vblank, i_cpu_req, i_cpu_addr, i_cpu_data,
    input  i_kbd_req, i_kbd_addr, i_kbd_data, i_clear,
    output o_cpu_gnt, o_kbd_gnt, o_clear_busy,
    output o_we, o_waddr, o_wdata, o_range_err
  );
endinterface

// File: rtl/text_buffer_scheduler.sv
// Single write port of the display character buffer: round-robin CPU/keyboard
// arbitration, full-buffer clear sequencer, optional vertical-blank write window.
module text_buffer_scheduler #(
  parameter int          DEPTH       = 328,
  parameter int          AW          = 9,
  parameter int          DW          = 32,
  parameter logic [31:0] BLANK       = 32'h0000_0020,
  parameter bit          VBLANK_ONLY = 1'b1
) (
  input  logic                    VGA_CLK_IN,
  input  logic                    i_rst_n,
  text_buffer_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [DW-1:0] BLANK_L   = DW'(BLANK);

  function automatic logic addr_in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_L);
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic          clr_pend_r;
  logic          clr_pend_nxt_s;
  logic [AW-1:0] clr_cnt_r;
  logic [AW-1:0] clr_cnt_nxt_s;
  logic          clr_busy_r;
  logic          clr_busy_nxt_s;
  logic          clr_we_s;
  logic          prio_kbd_r;

  logic          win_s;
  logic          busy_s;
  logic          clr_accept_s;
  logic          gnt_ok_s;
  logic          cpu_gnt_s;
  logic          kbd_gnt_s;
  logic          gnt_any_s;
  logic [AW-1:0] gnt_addr_s;
  logic [DW-1:0] gnt_data_s;
  logic          gnt_in_range_s;

  logic          we_r;
  logic [AW-1:0] waddr_r;
  logic [DW-1:0] wdata_r;
  logic          range_err_r;

  // Write window and busy qualification shared by arbitration and clear control
  always_comb begin
    win_s        = ~VBLANK_ONLY | bus.i_vblank;
    busy_s       = clr_pend_r | (state_r == ST_CLEAR) | clr_busy_r;
    clr_accept_s = bus.i_clear & ~busy_s;
    // A clear arriving in the same cycle beats any request
    gnt_ok_s     = i_rst_n & win_s & ~busy_s & ~bus.i_clear & (state_r == ST_IDLE);
  end

  // Round-robin grant; the grant is same-cycle because addr/data are taken in the gnt cycle
  always_comb begin
    cpu_gnt_s = 1'b0;
    kbd_gnt_s = 1'b0;
    if (gnt_ok_s) begin
      if (bus.i_cpu_req && bus.i_kbd_req) begin
        if (prio_kbd_r) begin
          kbd_gnt_s = 1'b1;
        end else begin
          cpu_gnt_s = 1'b1;
        end
      end else begin
        cpu_gnt_s = bus.i_cpu_req;
        kbd_gnt_s = bus.i_kbd_req;
      end
    end else begin
      cpu_gnt_s = 1'b0;
      kbd_gnt_s = 1'b0;
    end
  end

  // Select the granted channel's address and data
  always_comb begin
    gnt_any_s = cpu_gnt_s | kbd_gnt_s;
    if (cpu_gnt_s) begin
      gnt_addr_s = bus.i_cpu_addr;
      gnt_data_s = bus.i_cpu_data;
    end else begin
      gnt_addr_s = bus.i_kbd_addr;
      gnt_data_s = bus.i_kbd_data;
    end
    gnt_in_range_s = addr_in_range(gnt_addr_s);
  end

  // Clear sequencer next-state: pending -> sweep all entries while the window is open
  always_comb begin
    state_nxt_s    = state_r;
    clr_pend_nxt_s = clr_pend_r | clr_accept_s;
    clr_cnt_nxt_s  = clr_cnt_r;
    clr_we_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_pend_r && win_s) begin
          state_nxt_s    = ST_CLEAR;
          clr_pend_nxt_s = 1'b0;
          clr_cnt_nxt_s  = {AW{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (win_s) begin
          clr_we_s = 1'b1;
          if (clr_cnt_r == LAST_ADDR) begin
            state_nxt_s   = ST_IDLE;
            clr_cnt_nxt_s = {AW{1'b0}};
          end else begin
            clr_cnt_nxt_s = clr_cnt_r + AW'(1);
          end
        end else begin
          clr_we_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        clr_pend_nxt_s = 1'b0;
        clr_cnt_nxt_s  = {AW{1'b0}};
      end
    endcase
    // Busy stays up through the cycle that carries the last clear write
    clr_busy_nxt_s = clr_pend_nxt_s | (state_nxt_s == ST_CLEAR) | (state_r == ST_CLEAR);
  end

  // Control state registers
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      clr_pend_r <= 1'b0;
      clr_cnt_r  <= {AW{1'b0}};
      clr_busy_r <= 1'b0;
      prio_kbd_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      clr_pend_r <= clr_pend_nxt_s;
      clr_cnt_r  <= clr_cnt_nxt_s;
      clr_busy_r <= clr_busy_nxt_s;
      if (cpu_gnt_s) begin
        prio_kbd_r <= 1'b1;
      end else if (kbd_gnt_s) begin
        prio_kbd_r <= 1'b0;
      end else begin
        prio_kbd_r <= prio_kbd_r;
      end
    end
  end

  // Registered buffer write port; out-of-range grants become an error pulse instead
  always_ff @(posedge VGA_CLK_IN or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_r        <= 1'b0;
      waddr_r     <= {AW{1'b0}};
      wdata_r     <= {DW{1'b0}};
      range_err_r <= 1'b0;
    end else begin
      we_r        <= clr_we_s | (gnt_any_s & gnt_in_range_s);
      range_err_r <= gnt_any_s & ~gnt_in_range_s;
      if (clr_we_s) begin
        waddr_r <= clr_cnt_r;
        wdata_r <= BLANK_L;
      end else if (gnt_any_s && gnt_in_range_s) begin
        waddr_r <= gnt_addr_s;
        wdata_r <= gnt_data_s;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign bus.o_cpu_gnt    = cpu_gnt_s;
  assign bus.o_kbd_gnt    = kbd_gnt_s;
  assign bus.o_clear_busy = clr_busy_r;
  assign bus.o_we         = we_r;
  assign bus.o_waddr      = waddr_r;
  assign bus.o_wdata      = wdata_r;
  assign bus.o_range_err  = range_err_r;

endmodule

// File: tb/tb_text_buffer_scheduler.sv
// Bench for text_buffer_scheduler: vector table, clear/reset sequences, and
// randomized traffic against a rule-level reference model with a buffer image.
module tb_text_buffer_scheduler;

  localparam int          DEPTH = 328;
  localparam int          AW    = 9;
  localparam int          DW    = 32;
  localparam logic [31:0] BLANK = 32'h0000_0020;

  logic VGA_CLK_IN;
  logic i_rst_n;
  int   total;
  int   bad;

  text_buffer_scheduler_if #(.AW(AW), .DW(DW)) bus ();

  text_buffer_scheduler #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .BLANK(BLANK), .VBLANK_ONLY(1'b1)
  ) dut (
    .VGA_CLK_IN (VGA_CLK_IN),
    .i_rst_n    (i_rst_n),
    .bus        (bus)
  );

  initial begin
    VGA_CLK_IN = 1'b0;
    forever #5 VGA_CLK_IN = ~VGA_CLK_IN;
  end

  typedef struct {
    logic          vb;
    logic          cr;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          kr;
    logic [AW-1:0] ka;
    logic [DW-1:0] kd;
    logic          cg;
    logic          kg;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
  } vec_t;

  vec_t vecs [16];

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] act_mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic next_cycle;
    @(posedge VGA_CLK_IN);
    #1;
  endtask

  task automatic idle_inputs;
    bus.i_vblank   = 1'b0;
    bus.i_cpu_req  = 1'b0;
    bus.i_cpu_addr = '0;
    bus.i_cpu_data = '0;
    bus.i_kbd_req  = 1'b0;
    bus.i_kbd_addr = '0;
    bus.i_kbd_data = '0;
    bus.i_clear    = 1'b0;
  endtask

  task automatic do_reset;
    i_rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge VGA_CLK_IN);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Clear sweep with a concurrent CPU request; optional vblank gap inside the sweep
  task automatic run_clear(input int gap_start, input int gap_len, input string tag);
    int idx, prev_idx;
    bit vb, pres, prev_pres, done, gnt_prev, granted, finished, exp_gnt;
    idx = 0; prev_idx = 0; prev_pres = 0; done = 0;
    gnt_prev = 0; granted = 0; finished = 0;
    for (int c = 0; c < 900 && !finished; c++) begin
      vb = !(c >= gap_start && c < gap_start + gap_len);
      bus.i_vblank   = vb;
      bus.i_clear    = (c == 0 || c == 60);
      bus.i_cpu_req  = !granted;
      bus.i_cpu_addr = 9'd7;
      bus.i_cpu_data = 32'd70;
      @(negedge VGA_CLK_IN);
      exp_gnt = done && !granted && vb;
      chk({tag, "_busy"}, bus.o_clear_busy, (c >= 1) && !done);
      chk({tag, "_gnt"}, bus.o_cpu_gnt, exp_gnt);
      chk({tag, "_we"}, bus.o_we, prev_pres | gnt_prev);
      if (prev_pres) begin
        chk({tag, "_waddr"}, bus.o_waddr, prev_idx);
        chk({tag, "_wdata"}, bus.o_wdata, BLANK);
      end
      if (gnt_prev) begin
        chk({tag, "_cpu_waddr"}, bus.o_waddr, 9'd7);
        chk({tag, "_cpu_wdata"}, bus.o_wdata, 32'd70);
        finished = 1;
      end
      if (prev_pres && prev_idx == DEPTH - 1) done = 1;
      gnt_prev = exp_gnt;
      if (exp_gnt) granted = 1;
      pres = (c >= 2) && (idx < DEPTH) && vb;
      prev_pres = pres;
      prev_idx = idx;
      if (pres) idx++;
      next_cycle();
    end
    chk({tag, "_timeout"}, finished, 1'b1);
    idle_inputs();
  endtask

  // Reference model state for the randomized phase
  bit            m_busy, m_pend, m_clearing, m_prio_kbd;
  bit            m_we, m_we_clear, m_rerr;
  int            m_idx, m_addr;
  logic [DW-1:0] m_data;

  initial begin
    bit vb, e_cg, e_kg, cg_prev, kg_prev, accept;
    bit n_we, n_clr, n_rerr, n_busy;
    int n_addr, a, diffs;
    logic [DW-1:0] n_data, d;

    total = 0;
    bad   = 0;
    i_rst_n = 1'b0;
    idle_inputs();

    vecs[0]  = '{1'b0, 1'b1, 9'd5,   32'h41, 1'b0, 9'd0,   32'h0,  1'b0, 1'b0, 1'b0, 9'd0,   32'h0,  1'b0};
    vecs[1]  = '{1'b1, 1'b1, 9'd5,   32'h41, 1'b0, 9'd0,   32'h0,  1'b1, 1'b0, 1'b0, 9'd0,   32'h0,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b0, 9'd0,   32'h0,  1'b0, 1'b0, 1'b1, 9'd5,   32'h41, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 9'd1,   32'h11, 1'b1, 9'd2,   32'h22, 1'b0, 1'b1, 1'b0, 9'd0,   32'h0,  1'b0};
    vecs[4]  = '{1'b1, 1'b1, 9'd1,   32'h11, 1'b1, 9'd3,   32'h33, 1'b1, 1'b0, 1'b1, 9'd2,   32'h22, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 9'd4,   32'h44, 1'b1, 9'd3,   32'h33, 1'b0, 1'b1, 1'b1, 9'd1,   32'h11, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 9'd4,   32'h44, 1'b1, 9'd5,   32'h55, 1'b1, 1'b0, 1'b1, 9'd3,   32'h33, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 9'd6,   32'h66, 1'b1, 9'd5,   32'h55, 1'b0, 1'b0, 1'b1, 9'd4,   32'h44, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 9'd6,   32'h66, 1'b1, 9'd5,   32'h55, 1'b0, 1'b1, 1'b0, 9'd0,   32'h0,  1'b0};
    vecs[9]  = '{1'b1, 1'b1, 9'd6,   32'h66, 1'b0, 9'd0,   32'h0,  1'b1, 1'b0, 1'b1, 9'd5,   32'h55, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 9'd400, 32'h77, 1'b0, 9'd0,   32'h0,  1'b1, 1'b0, 1'b1, 9'd6,   32'h66, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b0, 9'd0,   32'h0,  1'b0, 1'b0, 1'b0, 9'd0,   32'h0,  1'b1};
    vecs[12] = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b1, 9'd327, 32'h99, 1'b0, 1'b1, 1'b0, 9'd0,   32'h0,  1'b0};
    vecs[13] = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b1, 9'd328, 32'h1,  1'b0, 1'b1, 1'b1, 9'd327, 32'h99, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b0, 9'd0,   32'h0,  1'b0, 1'b0, 1'b0, 9'd0,   32'h0,  1'b1};
    vecs[15] = '{1'b1, 1'b0, 9'd0,   32'h0,  1'b0, 9'd0,   32'h0,  1'b0, 1'b0, 1'b0, 9'd0,   32'h0,  1'b0};

    // Reset state, with a request and open window present during reset
    bus.i_vblank  = 1'b1;
    bus.i_cpu_req = 1'b1;
    repeat (2) @(posedge VGA_CLK_IN);
    @(negedge VGA_CLK_IN);
    chk("rst_we", bus.o_we, 1'b0);
    chk("rst_waddr", bus.o_waddr, 9'd0);
    chk("rst_wdata", bus.o_wdata, 32'd0);
    chk("rst_busy", bus.o_clear_busy, 1'b0);
    chk("rst_rerr", bus.o_range_err, 1'b0);
    chk("rst_cpu_gnt", bus.o_cpu_gnt, 1'b0);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      bus.i_vblank   = vecs[i].vb;
      bus.i_cpu_req  = vecs[i].cr;
      bus.i_cpu_addr = vecs[i].ca;
      bus.i_cpu_data = vecs[i].cd;
      bus.i_kbd_req  = vecs[i].kr;
      bus.i_kbd_addr = vecs[i].ka;
      bus.i_kbd_data = vecs[i].kd;
      @(negedge VGA_CLK_IN);
      chk($sformatf("vec%0d_cpu_gnt", i), bus.o_cpu_gnt, vecs[i].cg);
      chk($sformatf("vec%0d_kbd_gnt", i), bus.o_kbd_gnt, vecs[i].kg);
      chk($sformatf("vec%0d_we", i), bus.o_we, vecs[i].we);
      chk($sformatf("vec%0d_rerr", i), bus.o_range_err, vecs[i].re);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_waddr", i), bus.o_waddr, vecs[i].wa);
        chk($sformatf("vec%0d_wdata", i), bus.o_wdata, vecs[i].wd);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    run_clear(1000, 0, "clr_full");
    next_cycle();
    run_clear(102, 5, "clr_gap");
    next_cycle();

    // Reset in the middle of a clear sweep
    bus.i_vblank = 1'b1;
    bus.i_clear  = 1'b1;
    next_cycle();
    bus.i_clear = 1'b0;
    repeat (202) next_cycle();
    @(negedge VGA_CLK_IN);
    chk("midclr_we", bus.o_we, 1'b1);
    chk("midclr_waddr", bus.o_waddr, 9'd200);
    #2;
    i_rst_n = 1'b0;
    bus.i_cpu_req  = 1'b1;
    bus.i_cpu_addr = 9'd9;
    bus.i_cpu_data = 32'd99;
    #1;
    chk("rstclr_we", bus.o_we, 1'b0);
    chk("rstclr_waddr", bus.o_waddr, 9'd0);
    chk("rstclr_wdata", bus.o_wdata, 32'd0);
    chk("rstclr_busy", bus.o_clear_busy, 1'b0);
    chk("rstclr_gnt", bus.o_cpu_gnt, 1'b0);
    repeat (2) @(posedge VGA_CLK_IN);
    #1;
    bus.i_cpu_req = 1'b0;
    i_rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge VGA_CLK_IN);
      chk("postrst_we", bus.o_we, 1'b0);
      chk("postrst_busy", bus.o_clear_busy, 1'b0);
      next_cycle();
    end
    bus.i_cpu_req = 1'b1;
    @(negedge VGA_CLK_IN);
    chk("postrst_gnt", bus.o_cpu_gnt, 1'b1);
    next_cycle();
    bus.i_cpu_req = 1'b0;
    @(negedge VGA_CLK_IN);
    chk("postrst_wr_we", bus.o_we, 1'b1);
    chk("postrst_wr_addr", bus.o_waddr, 9'd9);
    chk("postrst_wr_data", bus.o_wdata, 32'd99);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    m_busy = 0; m_pend = 0; m_clearing = 0; m_prio_kbd = 0;
    m_we = 0; m_we_clear = 0; m_rerr = 0; m_idx = 0; m_addr = 0; m_data = '0;
    cg_prev = 0; kg_prev = 0; vb = 1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = '0;
      act_mem[i] = '0;
    end
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 19) == 0) vb = !vb;
      bus.i_vblank = vb;
      bus.i_clear  = ($urandom_range(0, 299) == 0);
      if (cg_prev) bus.i_cpu_req = 1'b0;
      else if (bus.i_cpu_req) begin
        if ($urandom_range(0, 39) == 0) bus.i_cpu_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.i_cpu_req  = 1'b1;
        bus.i_cpu_addr = ($urandom_range(0, 7) == 0) ? 9'(328 + $urandom_range(0, 183))
                                                     : 9'($urandom_range(0, 327));
        bus.i_cpu_data = $urandom;
      end
      if (kg_prev) bus.i_kbd_req = 1'b0;
      else if (bus.i_kbd_req) begin
        if ($urandom_range(0, 39) == 0) bus.i_kbd_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.i_kbd_req  = 1'b1;
        bus.i_kbd_addr = ($urandom_range(0, 7) == 0) ? 9'(328 + $urandom_range(0, 183))
                                                     : 9'($urandom_range(0, 327));
        bus.i_kbd_data = $urandom;
      end

      e_cg = 0; e_kg = 0;
      if (!m_busy && vb && !bus.i_clear) begin
        if (bus.i_cpu_req && bus.i_kbd_req) begin
          if (m_prio_kbd) e_kg = 1; else e_cg = 1;
        end else begin
          e_cg = bus.i_cpu_req;
          e_kg = bus.i_kbd_req;
        end
      end

      @(negedge VGA_CLK_IN);
      chk("rnd_cpu_gnt", bus.o_cpu_gnt, e_cg);
      chk("rnd_kbd_gnt", bus.o_kbd_gnt, e_kg);
      chk("rnd_we", bus.o_we, m_we);
      chk("rnd_busy", bus.o_clear_busy, m_busy);
      chk("rnd_rerr", bus.o_range_err, m_rerr);
      if (m_we) begin
        chk("rnd_waddr", bus.o_waddr, m_addr);
        chk("rnd_wdata", bus.o_wdata, m_data);
        exp_mem[m_addr] = m_data;
      end
      if (bus.o_we && bus.o_waddr < DEPTH) act_mem[bus.o_waddr] = bus.o_wdata;

      n_we = 0; n_clr = 0; n_rerr = 0; n_addr = m_addr; n_data = m_data;
      if (e_cg || e_kg) begin
        a = e_cg ? int'(bus.i_cpu_addr) : int'(bus.i_kbd_addr);
        d = e_cg ? bus.i_cpu_data : bus.i_kbd_data;
        if (a < DEPTH) begin
          n_we = 1; n_addr = a; n_data = d;
        end else begin
          n_rerr = 1;
        end
        m_prio_kbd = e_cg;
      end
      accept = bus.i_clear && !m_busy;
      if (m_clearing) begin
        if (vb) begin
          n_we = 1; n_clr = 1; n_addr = m_idx; n_data = BLANK;
          m_idx++;
          if (m_idx == DEPTH) m_clearing = 0;
        end
      end else if (m_pend && vb) begin
        m_clearing = 1; m_idx = 0; m_pend = 0;
      end
      n_busy = accept || (m_busy && !(m_we && m_we_clear && m_addr == DEPTH - 1));
      if (accept) m_pend = 1;
      m_we = n_we; m_we_clear = n_clr; m_rerr = n_rerr;
      m_addr = n_addr; m_data = n_data; m_busy = n_busy;
      cg_prev = e_cg; kg_prev = e_kg;
      next_cycle();
    end

    diffs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (exp_mem[i] !== act_mem[i]) diffs++;
    end
    chk("rnd_mem_image", diffs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
